// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one multiply-accumulate engine walks TAPS products per sample,
// with two runtime-loadable coefficient banks (low-pass / high-pass) selected per sample.
module fir_mac_seq #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int TAPS  = 8,
  parameter int SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             x_in,
  input  logic                      mode,
  input  logic                      coef_we,
  input  logic                      coef_sel,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [CW-1:0]             coef_data,
  output logic                      coef_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             y_out,
  output logic                      out_sat
);

  localparam int AW   = $clog2(TAPS);
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + AW;
  localparam int SW   = ACCW + 1;
  localparam logic signed [SW-1:0] RND  = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                 r_state, w_state_next;
  logic signed [DW-1:0]   r_dly  [TAPS];
  logic signed [CW-1:0]   r_coef [2][TAPS];
  logic signed [ACCW-1:0] r_acc;
  logic [AW-1:0]          r_idx;
  logic                   r_mode;
  logic [DW-1:0]          r_y;
  logic                   r_sat;
  logic                   r_coef_err;

  logic                   w_accept, w_last, w_addr_ok, w_coef_ok, w_coef_bad;
  logic signed [PW-1:0]   w_dx, w_cx, w_prod;
  logic signed [ACCW-1:0] w_acc_next;
  logic signed [SW-1:0]   w_sum, w_shr;
  logic                   w_hi, w_lo;
  logic [DW-1:0]          w_y;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_idx == AW'(TAPS - 1));
  assign w_addr_ok  = (int'(coef_addr) < TAPS);
  // Coefficients may only change while no sample is being processed.
  assign w_coef_ok  = coef_we && in_ready && w_addr_ok;
  assign w_coef_bad = coef_we && !w_coef_ok;

  assign w_dx       = $signed({{CW{r_dly[r_idx][DW-1]}}, r_dly[r_idx]});
  assign w_cx       = $signed({{DW{r_coef[r_mode][r_idx][CW-1]}}, r_coef[r_mode][r_idx]});
  assign w_prod     = w_dx * w_cx;
  assign w_acc_next = r_acc + $signed({{AW{w_prod[PW-1]}}, w_prod});

  // Round-half-up, scale, then clip to the signed output range.
  assign w_sum = $signed({w_acc_next[ACCW-1], w_acc_next}) + RND;
  assign w_shr = w_sum >>> SHIFT;
  assign w_hi  = (w_shr > MAXV);
  assign w_lo  = (w_shr < MINV);
  assign w_y   = w_hi ? MAXV[DW-1:0] : (w_lo ? MINV[DW-1:0] : w_shr[DW-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_MAC;
      S_MAC:   if (w_last)    w_state_next = S_OUT;
      S_OUT:   if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_dly[i]     <= '0;
        r_coef[0][i] <= '0;
        r_coef[1][i] <= '0;
      end
      r_acc      <= '0;
      r_idx      <= '0;
      r_mode     <= 1'b0;
      r_y        <= '0;
      r_sat      <= 1'b0;
      r_coef_err <= 1'b0;
    end else begin
      r_coef_err <= w_coef_bad;
      if (w_coef_ok) r_coef[coef_sel][coef_addr] <= coef_data;
      if (w_accept) begin
        r_dly[0] <= x_in;
        for (int i = 1; i < TAPS; i++) r_dly[i] <= r_dly[i-1];
        r_mode <= mode;
        r_acc  <= '0;
        r_idx  <= '0;
      end else if (r_state == S_MAC) begin
        r_acc <= w_acc_next;
        r_idx <= r_idx + AW'(1);
        if (w_last) begin
          r_y   <= w_y;
          r_sat <= w_hi | w_lo;
        end
      end
    end
  end

  assign y_out    = r_y;
  assign out_sat  = r_sat;
  assign coef_err = r_coef_err;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: stimulus pushes model predictions, a negedge monitor
// pops and compares every presented output, including latency and hold-under-backpressure.
module tb_fir_mac_seq;
  localparam int DW = 16, CW = 16, TAPS = 8, SHIFT = 15;
  localparam int AW = $clog2(TAPS);
  localparam int MAXI = (1 << (DW - 1)) - 1;
  localparam int MINI = -(1 << (DW - 1));

  logic          clk = 1'b0, reset = 1'b1;
  logic          in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic          coef_we = 1'b0, coef_sel = 1'b0;
  logic [DW-1:0] x_in = '0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          in_ready, coef_err, out_valid, out_sat;
  logic [DW-1:0] y_out;

  typedef struct {int y; bit s; int t;} exp_t;
  exp_t exp_q[$];
  int   hist[$];
  int   coef_m[2][TAPS];
  int   checks = 0, errors = 0, cyc = 0, ready_mode = 0;
  bit   prev_ov = 1'b0;

  fir_mac_seq #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .mode(mode), .coef_we(coef_we), .coef_sel(coef_sel), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err), .out_valid(out_valid),
    .out_ready(out_ready), .y_out(y_out), .out_sat(out_sat));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < TAPS; k++) coef_m[b][k] = 0;
  endfunction

  // y = sat(round(sum_k x[n-k] * c[k] / 2^SHIFT)) over the last TAPS accepted samples.
  function automatic exp_t predict(bit m, int t);
    longint acc = 0;
    longint r;
    exp_t   e;
    for (int k = 0; k < TAPS; k++) begin
      longint xk = (k < hist.size()) ? longint'(hist[k]) : 0;
      acc += xk * longint'(coef_m[m][k]);
    end
    r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    e.s = 1'b1;
    if (r > MAXI)      e.y = MAXI;
    else if (r < MINI) e.y = MINI;
    else begin e.y = int'(r); e.s = 1'b0; end
    e.t = t;
    return e;
  endfunction

  // Monitor: drives out_ready, checks every cycle an output is presented.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: out_valid=1 y_out=%0d, required no pending output", $signed(y_out));
        end else begin
          if (!prev_ov) check("latency", cyc, exp_q[0].t + TAPS + 1);
          check("y_out", int'($signed(y_out)), exp_q[0].y);
          check("out_sat", int'(out_sat), int'(exp_q[0].s));
          check("in_ready_during_out", int'(in_ready), 0);
          if (out_ready) begin
            $display("out t=%0d y=%0d sat=%0d", cyc, $signed(y_out), out_sat);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL ready_timeout: in_ready=0 after %0d cycles, required 1", n);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(int x, bit m, bit wr = 1'b0, int waddr = 0, int wdata = 0);
    wait_ready();
    x_in = x[DW-1:0]; mode = m; in_valid = 1'b1;
    if (wr) begin
      coef_we = 1'b1; coef_sel = m; coef_addr = waddr[AW-1:0]; coef_data = wdata[CW-1:0];
      coef_m[m][waddr] = wdata;
    end
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
    exp_q.push_back(predict(m, cyc));
    $display("in  t=%0d x=%0d mode=%0d wr=%0d", cyc, x, m, wr);
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    if (wr) check("coef_err_coincident", int'(coef_err), 0);
  endtask

  task automatic wr_idle(bit sel, int addr, int data);
    wait_ready();
    coef_we = 1'b1; coef_sel = sel; coef_addr = addr[AW-1:0]; coef_data = data[CW-1:0];
    coef_m[sel][addr] = data;
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_err_idle", int'(coef_err), 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", exp_q.size());
    end
  endtask

  function automatic int rnd_coef();
    return int'($urandom_range(0, 40000)) - 20000;
  endfunction

  function automatic int rnd_x();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int lp[TAPS] = '{1475, 2950, 4915, 7032, 7032, 4915, 2950, 1475};
    int n;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_coef_err", int'(coef_err), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);

    // Impulse through the low-pass bank returns the taps themselves.
    for (int k = 0; k < TAPS; k++) wr_idle(1'b0, k, lp[k]);
    send(32767, 1'b0);
    repeat (TAPS - 1) send(0, 1'b0);
    drain();

    // Coefficient write while the engine is busy is rejected.
    send(1234, 1'b0);
    coef_we = 1'b1; coef_sel = 1'b0; coef_addr = '0; coef_data = 16'hB1E0;
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_err_busy_pulse", int'(coef_err), 1);
    @(negedge clk);
    check("coef_err_busy_clear", int'(coef_err), 0);
    send(-5000, 1'b0);
    drain();

    // Write coincident with acceptance is used by that very sample.
    send(20000, 1'b1, 1'b1, 0, 15000);
    drain();

    // Backpressure: output holds, new samples are ignored.
    ready_mode = 2;
    send(12345, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_out_valid_seen", int'(out_valid), 1);
    in_valid = 1'b1; x_in = 16'd7;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid_hold", int'(out_valid), 1);
      check("bp_in_ready_low", int'(in_ready), 0);
    end
    @(posedge clk); #1;
    ready_mode = 0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_in_ready", int'(in_ready), 1);
    check("bp_idle_out_valid", int'(out_valid), 0);

    // Saturation through an all-max high-pass bank.
    for (int k = 0; k < TAPS; k++) wr_idle(1'b1, k, 32767);
    repeat (TAPS) send(32767, 1'b1);
    repeat (TAPS) send(-32768, 1'b1);
    drain();

    // Alternating modes over distinct random banks.
    for (int k = 0; k < TAPS; k++) begin
      wr_idle(1'b0, k, rnd_coef());
      wr_idle(1'b1, k, rnd_coef());
    end
    for (int i = 0; i < 16; i++) send(rnd_x(), i[0]);
    drain();

    // Random traffic with random downstream stalls and occasional reloads.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) wr_idle(1'($urandom_range(0, 1)), int'($urandom_range(0, TAPS - 1)), rnd_coef());
      send(rnd_x(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    ready_mode = 0;

    // Reset in the middle of accumulation discards the sample and clears both banks.
    send(30000, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_y_out", int'(y_out), 0);
    check("midrst_out_sat", int'(out_sat), 0);
    check("midrst_coef_err", int'(coef_err), 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (TAPS + 4) @(negedge clk);
    send(32767, 1'b0);
    repeat (TAPS - 1) send(0, 1'b0);
    send(32767, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 SHALL have parameter DW, default 16: sample width, signed.
REQ-002 SHALL have parameter CW, default 16: coefficient width, signed.
REQ-003 SHALL have parameter TAPS, default 8, range 2..64: filter length.
REQ-004 SHALL have parameter SHIFT, default 15: output scaling right-shift (Q15).
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: x_in and mode valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a sample.
REQ-009 SHALL have port x_in, input, DW: input sample.
REQ-010 SHALL have port mode, input, 1: bank select per sample, 0 = low-pass, 1 = high-pass.
REQ-011 SHALL have port coef_we, input, 1: coefficient write strobe.
REQ-012 SHALL have port coef_sel, input, 1: bank written, 0 = LP, 1 = HP.
REQ-013 SHALL have port coef_addr, input, clog2(TAPS): tap index written.
REQ-014 SHALL have port coef_data, input, CW: coefficient value.
REQ-015 SHALL have port coef_err, output, 1: one-cycle pulse, write rejected.
REQ-016 SHALL have port out_valid, output, 1: y_out valid.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts y_out.
REQ-018 SHALL have port y_out, output, DW: filtered sample.
REQ-019 SHALL have port out_sat, output, 1: y_out was saturated; qualified by out_valid.

Function
REQ-020 SHALL implement one time-multiplexed multiply-accumulate engine; FSM states IDLE, MAC, OUT.
REQ-021 In IDLE, in_ready SHALL be 1; in MAC and OUT, in_ready SHALL be 0.
REQ-022 On in_valid && in_ready, the block SHALL shift the delay line (d[k] <= d[k-1], d[0] <= x_in), latch mode, clear acc, set idx=0, and enter MAC.
REQ-023 In MAC, each cycle SHALL do acc += d[idx] * c[mode_latched][idx] and idx++; after TAPS cycles, the block SHALL enter OUT.
REQ-024 acc SHALL be DW+CW+clog2(TAPS) bits signed; no intermediate overflow is permitted.
REQ-025 The result SHALL be (acc + 2^(SHIFT-1)) >>> SHIFT, saturated to signed DW; out_sat SHALL be 1 iff clipping occurred.
REQ-026 In OUT, out_valid SHALL be 1, and y_out and out_sat SHALL be stable until out_ready=1; on out_ready=1, the block SHALL return to IDLE.
REQ-027 Latency: a sample accepted at cycle T SHALL produce out_valid=1 at cycle T+TAPS+1; minimum sample spacing SHALL be TAPS+2 cycles.
REQ-028 A coefficient write SHALL be accepted only in IDLE; a write in MAC or OUT SHALL be dropped and SHALL pulse coef_err for 1 cycle.
REQ-029 A write coincident with sample acceptance SHALL take effect, and the new coefficient SHALL be used by that sample.
REQ-030 TAPS not a power of two: a write with coef_addr >= TAPS SHALL be dropped and SHALL pulse coef_err.
REQ-031 mode SHALL be sampled only at acceptance; changes during MAC/OUT SHALL have no effect.

Reset
REQ-032 Reset SHALL take effect immediately, in any state, including mid-MAC: FSM to IDLE, delay line, acc, idx, both coefficient banks = 0; out_valid, out_sat, coef_err = 0; y_out = 0; in_ready = 1 after release.
REQ-033 An in-flight sample SHALL be discarded; no out_valid SHALL appear for it.

Verification
REQ-034 Impulse LP: load LP bank 1475,2950,4915,7032,7032,4915,2950,1475; x=32767 then 7 zeros, mode=0, out_ready=1 -> y_out = 1475,2950,4915,7032,7032,4915,2950,1475; out_sat=0; each out_valid exactly 9 cycles after acceptance.
REQ-035 Saturation HP: HP bank all 32767; 8 samples x=32767, mode=1 -> 8th y_out=32767, out_sat=1; x=-32768 x8 -> y_out=-32768, out_sat=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, y_out stable, in_ready=0, in_valid ignored; then out_ready=1 -> IDLE next cycle.
REQ-037 Coefficient write during MAC -> coef_err pulses 1 cycle; bank unchanged; result identical to no-write run.
REQ-038 Reset asserted mid-MAC -> out_valid never rises for that sample; after release, impulse x=32767 -> outputs all 0 (banks cleared).
REQ-039 Per-sample mode switch: same bank contents, alternate mode 0/1 on successive samples -> each result matches a golden model using the latched mode; no cross-bank mixing.
